sn_bus_writer: RTL and testbench

Host-side bus master for the SN76489-compatible sound core. It accepts register-write commands (channel/type address plus 10-bit value), encodes them into the chip's latch/data byte format, and drives the 8-bit parallel data bus and active-low write strobe with setup, strobe and hold timing. It waits on the core's READY line before ending each strobe. It is the transmitting end of the core's parallel write interface and is used by test sequencers and the on-board music player.

---
 rtl/sn_bus_writer.sv | 156 +++++++++++++++
 tb/tb_sn_bus_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sn_bus_writer.sv
// Bus master for the SN76489-compatible core: turns register-write commands into
// latch/data bytes and drives pd/web with setup, strobe (READY-stretched) and hold phases.
module sn_bus_writer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_addr,
  input  logic [9:0] cmd_value,
  output logic [7:0] pd,
  output logic       web,
  input  logic       ready,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned STROBE_MAX = PULSE_CYC + TIMEOUT_CYC;
  localparam int unsigned SH_MAX     = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CNT_MAX    = (STROBE_MAX > SH_MAX) ? STROBE_MAX : SH_MAX;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_MAX - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pd_q, pd_d;
  logic [7:0]    data_q, data_d;
  logic          pending_q, pending_d;
  logic          web_q, busy_q, cmd_ready_q, timeout_q, timeout_d;

  // Noise control (cc=3, t=0) carries only 3 value bits; bit 3 of its latch byte is 0.
  function automatic logic [7:0] latch_byte(input logic [2:0] addr, input logic [9:0] value);
    logic [3:0] d;
    if (addr == 3'b110) begin
      d = {1'b0, value[2:0]};
    end else begin
      d = value[3:0];
    end
    return {1'b1, addr, d};
  endfunction

  function automatic logic is_tone(input logic [2:0] addr);
    return (addr[0] == 1'b0) && (addr[2:1] != 2'd3);
  endfunction

  // Next-state, counter and byte-staging logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    pd_d      = pd_q;
    data_d    = data_q;
    pending_d = pending_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d   = SETUP;
          pd_d      = latch_byte(cmd_addr, cmd_value);
          data_d    = {2'b00, cmd_value[9:4]};
          pending_d = is_tone(cmd_addr);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          state_d = SETUP;
        end
      end
      STROBE: begin
        // A late READY on the very last allowed cycle still counts as a normal finish.
        if ((cnt_q >= PULSE_LAST) && ready) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STROBE_LAST) begin
          state_d   = HOLD;
          cnt_d     = '0;
          timeout_d = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = STROBE;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (pending_q) begin
            state_d   = SETUP;
            pd_d      = data_q;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pd_q        <= 8'h00;
      data_q      <= 8'h00;
      pending_q   <= 1'b0;
      web_q       <= 1'b1;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pd_q        <= pd_d;
      data_q      <= data_d;
      pending_q   <= pending_d;
      web_q       <= (state_d != STROBE);
      busy_q      <= (state_d != IDLE);
      cmd_ready_q <= (state_d == IDLE);
      timeout_q   <= timeout_d;
    end
  end

  assign pd        = pd_q;
  assign web       = web_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sn_bus_writer.sv
// Randomized self-checking bench for sn_bus_writer against a per-command timing/encoding model.
module tb_sn_bus_writer;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [9:0] cmd_value;
  logic [7:0] pd;
  logic       web;
  logic       ready;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cfg = 0;

  sn_bus_writer #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_value(cmd_value), .pd(pd), .web(web),
    .ready(ready), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Core model: READY stays low for the first stall_cfg cycles of every strobe.
  initial begin
    int k;
    k = 0;
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (web == 1'b0) begin
        ready = (k >= stall_cfg);
        k++;
      end else begin
        k = 0;
        ready = (stall_cfg == 0);
      end
    end
  end

  task automatic run_cmd(input logic [2:0] a, input logic [9:0] v, input int stall);
    int k, lows, cur_low, to_cnt, to_k, done_k, pd_changes, guard;
    int low_start[2], low_len[2];
    logic [7:0] low_pd[2];
    logic [7:0] first_pd, prev_pd, exp_latch, exp_data;
    logic prev_web, exp_to, tone;
    int L, nb;
    stall_cfg = stall;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_cmd", cmd_ready, 1);
    cmd_addr = a; cmd_value = v; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_addr = 3'($urandom); cmd_value = 10'($urandom);
    k = 0; lows = 0; cur_low = 0; to_cnt = 0; to_k = -1; done_k = -1; pd_changes = 0;
    low_start[0] = -1; low_start[1] = -1; low_len[0] = 0; low_len[1] = 0;
    low_pd[0] = 8'h00; low_pd[1] = 8'h00; first_pd = 8'h00; prev_pd = 8'h00; prev_web = 1'b1;
    while (done_k < 0 && k < 700) begin
      @(negedge clk);
      k++;
      if (k == 1) first_pd = pd;
      else if (pd != prev_pd) pd_changes++;
      prev_pd = pd;
      if (timeout) begin to_cnt++; to_k = k; end
      if (!web && prev_web) begin
        if (lows < 2) begin low_start[lows] = k; low_pd[lows] = pd; end
        cur_low = 0;
      end
      if (!web) cur_low++;
      if (web && !prev_web) begin
        if (lows < 2) low_len[lows] = cur_low;
        lows++;
      end
      prev_web = web;
      if (cmd_ready) done_k = k;
    end
    // Expected behaviour derived from the command and stall alone.
    tone = (a[0] == 1'b0) && (a[2:1] != 2'd3);
    exp_latch = 8'h80 | (8'(a) << 4) | ((a == 3'b110) ? (8'(v) & 8'h07) : (8'(v) & 8'h0F));
    exp_data  = 8'(v >> 4) & 8'h3F;
    if (stall >= P + TO) begin L = P + TO; exp_to = 1'b1; end
    else begin L = (stall + 1 > P) ? stall + 1 : P; exp_to = 1'b0; end
    nb = (tone && !exp_to) ? 2 : 1;
    check("latch_on_bus", first_pd, exp_latch);
    check("strobe_count", lows, nb);
    check("strobe0_byte", low_pd[0], exp_latch);
    check("strobe0_start", low_start[0], 1 + S);
    check("strobe0_len", low_len[0], L);
    check("timeout_pulses", to_cnt, exp_to);
    if (exp_to) check("timeout_cycle", to_k, 1 + S + L);
    check("pd_changes", pd_changes, nb - 1);
    check("done_cycle", done_k, 1 + nb * (S + L + H));
    if (nb == 2) begin
      check("strobe1_byte", low_pd[1], exp_data);
      check("strobe1_start", low_start[1], 1 + (S + L + H) + S);
      check("strobe1_len", low_len[1], L);
    end
  endtask

  initial begin
    int guard;
    int st;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_addr = 3'b100; cmd_value = 10'h2A7;
    repeat (3) @(negedge clk);
    check("rst_web", web, 1);
    check("rst_pd", pd, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    run_cmd(3'b011, 10'h005, 0);
    run_cmd(3'b100, 10'h2A7, 0);
    run_cmd(3'b110, 10'h3FF, 0);
    run_cmd(3'b011, 10'h00A, 10);
    run_cmd(3'b100, 10'h2A7, 1000);
    run_cmd(3'b010, 10'h155, 3);
    run_cmd(3'b000, 10'h3C9, 4);
    run_cmd(3'b000, 10'h0F1, P + TO - 1);
    run_cmd(3'b001, 10'h00E, P + TO);

    for (int i = 0; i < 30; i++) begin
      st = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 12));
      run_cmd(3'($urandom), 10'($urandom), st);
    end

    // Reset in the middle of a strobe drops the command.
    stall_cfg = 1000;
    @(negedge clk);
    cmd_addr = 3'b100; cmd_value = 10'h123; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (web && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("midop_in_strobe", web, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midop_rst_web", web, 1);
    check("midop_rst_busy", busy, 0);
    check("midop_rst_pd", pd, 8'h00);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midop_dropped_busy", busy, 0);
    check("midop_dropped_web", web, 1);
    check("midop_dropped_ready", cmd_ready, 1);
    stall_cfg = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
